// File: rtl/riscv_control_if.sv
// riscv_control_if: control/status bundle between the multicycle control FSM and its datapath.
interface riscv_control_if;
   logic [31:0] instr;
   logic        zero, carry, sign, overflow, mem_ready;
   logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [2:0]  imm_src;
   logic [3:0]  alu_control;
   modport master (
      input  instr, zero, carry, sign, overflow, mem_ready,
      output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
             alu_src_a, alu_src_b, result_src, imm_src, alu_control
   );
   modport slave (
      output instr, zero, carry, sign, overflow, mem_ready,
      input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal,
             alu_src_a, alu_src_b, result_src, imm_src, alu_control
   );
endinterface

// File: rtl/riscv_control_fsm.sv
// riscv_control_fsm: multicycle RISC-V control unit sequencing fetch, decode, memory, ALU and branch steps.
module riscv_control_fsm #(
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input logic clk,
   input logic rst_n,
   riscv_control_if.master bus
);
   localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
                          MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
                          ALUWB = 4'd8, BRANCH = 4'd9, JAL = 4'd10, LUI = 4'd11, TRAP = 4'd12;
   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                          ALU_OR = 4'b0011, ALU_SLT = 4'b0101, ALU_PASS = 4'b0111,
                          ALU_SRL = 4'b1000, ALU_SRA = 4'b1001, ALU_SLL = 4'b1010;
   logic [3:0] state, state_nx, exec_op, bad_nx;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b, exec_ok, br_ok, taken, unused_bits;
   assign opcode = bus.instr[6:0];
   assign funct3 = bus.instr[14:12];
   assign f7b = bus.instr[30];
   assign unused_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
   assign bad_nx = TRAP_ON_ILLEGAL ? TRAP : FETCH;
   assign exec_ok = funct3 != 3'b100 && funct3 != 3'b011;
   assign br_ok = funct3[2:1] != 2'b01;
   // funct3[0] inverts the base condition: beq/bne, blt/bge, bltu/bgeu
   assign taken = br_ok && ((funct3[2] ? (funct3[1] ? bus.carry : bus.sign ^ bus.overflow) : bus.zero) ^ funct3[0]);
   assign exec_op = funct3 == 3'b000 ? ((state == EXEC_R && f7b) ? ALU_SUB : ALU_ADD) :
                    funct3 == 3'b111 ? ALU_AND :
                    funct3 == 3'b110 ? ALU_OR :
                    funct3 == 3'b010 ? ALU_SLT :
                    funct3 == 3'b001 ? ALU_SLL :
                    funct3 == 3'b101 ? (f7b ? ALU_SRA : ALU_SRL) : ALU_ADD;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= FETCH;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         FETCH:            state_nx = bus.mem_ready ? DECODE : FETCH;
         DECODE:
            case (opcode)
               7'b0000011, 7'b0100011: state_nx = MEMADR;
               7'b0110011:             state_nx = EXEC_R;
               7'b0010011:             state_nx = EXEC_I;
               7'b1100011:             state_nx = BRANCH;
               7'b1101111:             state_nx = JAL;
               7'b0110111:             state_nx = LUI;
               default:                state_nx = bad_nx;
            endcase
         MEMADR:           state_nx = opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:          state_nx = bus.mem_ready ? MEMWB : MEMREAD;
         MEMWRITE:         state_nx = bus.mem_ready ? FETCH : MEMWRITE;
         MEMWB, ALUWB:     state_nx = FETCH;
         EXEC_R, EXEC_I:   state_nx = exec_ok ? ALUWB : bad_nx;
         BRANCH:           state_nx = br_ok ? FETCH : bad_nx;
         JAL, LUI:         state_nx = ALUWB;
         TRAP:             state_nx = TRAP;
         default:          state_nx = FETCH;
      endcase
   end
   always_comb begin
      bus.mem_req = 1'b0;
      bus.mem_write = 1'b0;
      bus.adr_src = 1'b0;
      bus.ir_write = 1'b0;
      bus.pc_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.illegal = state == TRAP;
      bus.alu_src_a = 2'd0;
      bus.alu_src_b = 2'd0;
      bus.result_src = 2'd0;
      bus.imm_src = 3'd0;
      bus.alu_control = ALU_ADD;
      case (state)
         FETCH: begin
            bus.mem_req = 1'b1;
            bus.alu_src_b = 2'd2;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
         end
         DECODE: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd1;
            bus.imm_src = 3'd2;
         end
         MEMADR: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 2'd1;
            bus.imm_src = opcode[5] ? 3'd1 : 3'd0;
         end
         MEMREAD, MEMWRITE: begin
            bus.mem_req = 1'b1;
            bus.adr_src = 1'b1;
            bus.mem_write = state == MEMWRITE;
         end
         MEMWB: begin
            bus.result_src = 2'd1;
            bus.reg_write = 1'b1;
         end
         EXEC_R, EXEC_I: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = state == EXEC_I ? 2'd1 : 2'd0;
            bus.alu_control = exec_op;
         end
         ALUWB: bus.reg_write = 1'b1;
         BRANCH: begin
            bus.alu_src_a = 2'd2;
            bus.imm_src = 3'd2;
            bus.alu_control = ALU_SUB;
            bus.pc_write = taken;
         end
         JAL: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 2'd2;
            bus.imm_src = 3'd3;
            bus.pc_write = 1'b1;
         end
         LUI: begin
            bus.alu_src_b = 2'd1;
            bus.imm_src = 3'd4;
            bus.alu_control = ALU_PASS;
         end
         default: ;
      endcase
      // reset kills any in-flight request without waiting for a clock edge
      if (!rst_n) begin
         bus.mem_req = 1'b0;
         bus.mem_write = 1'b0;
         bus.ir_write = 1'b0;
         bus.pc_write = 1'b0;
         bus.reg_write = 1'b0;
      end
   end
endmodule
